// File: rtl/stream_byte_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : stream_byte_serializer_if
//  Description : Bundles the beat-side (strb/data/last) and byte-side
//                (data/keep/last) valid/ready streams plus the packet byte
//                counter of the stream byte serializer.
//                slave  - serializer view (consumes beats, produces bytes)
//                master - environment view (produces beats, consumes bytes)
//  Ports       : in_valid/in_ready/in_bits_{strb,data,last}   beat stream
//                out_valid/out_ready/out_bits_{data,keep,last} byte stream
//                pkt_len                                       keep=1 count
//  Revision    : 1.0 - initial release
// ============================================================================
interface stream_byte_serializer_if #(
  parameter int p_DATA_BITS = 32,
  parameter int p_STRB_BITS = 4,
  parameter int p_LEN_BITS  = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [p_STRB_BITS-1:0] in_bits_strb;
  logic [p_DATA_BITS-1:0] in_bits_data;
  logic                   in_bits_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [7:0]             out_bits_data;
  logic                   out_bits_keep;
  logic                   out_bits_last;
  logic [p_LEN_BITS-1:0]  pkt_len;

  modport slave (
    input  in_valid, in_bits_strb, in_bits_data, in_bits_last, out_ready,
    output in_ready, out_valid, out_bits_data, out_bits_keep, out_bits_last,
           pkt_len
  );

  modport master (
    output in_valid, in_bits_strb, in_bits_data, in_bits_last, out_ready,
    input  in_ready, out_valid, out_bits_data, out_bits_keep, out_bits_last,
           pkt_len
  );
endinterface
`default_nettype wire

// File: rtl/stream_byte_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : stream_byte_serializer
//  Description : Takes one p_DATA_BITS beat at a time and emits its
//                strobe-enabled bytes one per cycle, lowest lane first, on a
//                byte-wide valid/ready stream that keeps packet boundaries.
//                A zero-strobe last beat produces a single keep=0 terminator.
//  Ports       : clk   - clock, all state on rising edge
//                rst_n - asynchronous active-low reset
//                bus   - stream_byte_serializer_if.slave (beat in, byte out,
//                        pkt_len)
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_byte_serializer #(
  parameter int p_DATA_BITS = 32,
  parameter int p_STRB_BITS = 4,
  parameter int p_LEN_BITS  = 16
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  stream_byte_serializer_if.slave   bus
);

  localparam int c_IDX_BITS = (p_STRB_BITS > 1) ? $clog2(p_STRB_BITS) : 1;

  logic                   busy_q, busy_d;
  logic [p_DATA_BITS-1:0] data_q, data_d;
  logic [p_STRB_BITS-1:0] rem_q,  rem_d;
  logic                   last_q, last_d;
  logic                   null_q, null_d;
  logic [p_LEN_BITS-1:0]  len_q,  len_d;

  logic [c_IDX_BITS-1:0]  w_cur;
  logic                   w_is_final;
  logic                   w_out_hs;
  logic                   w_accept;
  logic                   w_in_ready;
  logic                   w_out_last;
  logic [7:0]             w_lanes [p_STRB_BITS];

  // Split the held beat into byte lanes so the current lane is a plain index.
  for (genvar k = 0; k < p_STRB_BITS; k++) begin : g_lane
    assign w_lanes[k] = data_q[8*k +: 8];
  end

  // Lowest remaining lane: scan high to low so the lowest set bit wins.
  always_comb begin
    w_cur = '0;
    for (int i = p_STRB_BITS - 1; i >= 0; i--) begin
      if (rem_q[i]) w_cur = c_IDX_BITS'(i);
    end
  end

  // The held beat is on its last output when it is a terminator or only one
  // lane remains (power-of-two test on the remaining mask).
  assign w_is_final = null_q ||
                      ((rem_q != '0) && ((rem_q & (rem_q - p_STRB_BITS'(1))) == '0));

  assign w_out_hs   = busy_q && bus.out_ready;
  // Accepting while the final byte leaves avoids a bubble between beats.
  assign w_in_ready = !busy_q || (bus.out_ready && w_is_final);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_out_last = busy_q && last_q && w_is_final;

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = busy_q;
  assign bus.out_bits_data = (busy_q && !null_q) ? w_lanes[w_cur] : 8'h00;
  assign bus.out_bits_keep = busy_q && !null_q;
  assign bus.out_bits_last = w_out_last;
  assign bus.pkt_len       = len_q;

  always_comb begin
    busy_d = busy_q;
    data_d = data_q;
    rem_d  = rem_q;
    last_d = last_q;
    null_d = null_q;
    len_d  = len_q;

    if (w_out_hs) begin
      rem_d = rem_q & ~(p_STRB_BITS'(1) << w_cur);
      if (w_is_final) begin
        busy_d = 1'b0;
        null_d = 1'b0;
        last_d = 1'b0;
      end
      // The byte carrying last closes the packet and is not counted.
      if (w_out_last) begin
        len_d = '0;
      end else if (!null_q && (len_q != '1)) begin
        len_d = len_q + p_LEN_BITS'(1);
      end
    end

    if (w_accept) begin
      if (bus.in_bits_strb != '0) begin
        data_d = bus.in_bits_data;
        rem_d  = bus.in_bits_strb;
        last_d = bus.in_bits_last;
        null_d = 1'b0;
        busy_d = 1'b1;
      end else if (bus.in_bits_last) begin
        rem_d  = '0;
        null_d = 1'b1;
        last_d = 1'b1;
        busy_d = 1'b1;
      end
      // Zero-strobe non-last beats are swallowed without touching state.
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      data_q <= '0;
      rem_q  <= '0;
      last_q <= 1'b0;
      null_q <= 1'b0;
      len_q  <= '0;
    end else begin
      busy_q <= busy_d;
      data_q <= data_d;
      rem_q  <= rem_d;
      last_q <= last_d;
      null_q <= null_d;
      len_q  <= len_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_byte_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_byte_serializer
//  Description : Self-checking bench for stream_byte_serializer: directed
//                scenarios plus a randomized run against a queue-based model
//                of the expected byte stream and packet length.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_byte_serializer;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int LW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_byte_serializer_if #(.p_DATA_BITS(DW), .p_STRB_BITS(SW), .p_LEN_BITS(LW)) bus ();

  stream_byte_serializer #(.p_DATA_BITS(DW), .p_STRB_BITS(SW), .p_LEN_BITS(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] d;
    logic       k;
    logic       l;
  } exp_t;

  task automatic set_in(input logic v, input logic [SW-1:0] s,
                        input logic [DW-1:0] d, input logic l);
    bus.in_valid     = v;
    bus.in_bits_strb = s;
    bus.in_bits_data = d;
    bus.in_bits_last = l;
  endtask

  task automatic test_reset();
    set_in(1'b0, '0, '0, 1'b0);
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.pkt_len !== 16'd0) begin errors++; $display("FAIL reset_pkt_len: got %0d want 0", bus.pkt_len); end
    checks++; if ({bus.out_bits_data, bus.out_bits_keep, bus.out_bits_last} !== 10'd0) begin
      errors++; $display("FAIL reset_out_bits: got %h want 0", {bus.out_bits_data, bus.out_bits_keep, bus.out_bits_last}); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_full_beat();
    logic [DW-1:0] d;
    d = 32'h44332211;
    @(negedge clk); set_in(1'b1, 4'hF, d, 1'b1); bus.out_ready = 1'b1; #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready: got %b want 1", bus.in_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); set_in(1'b0, '0, '0, 1'b0); #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_bits_data !== d[8*i +: 8] || bus.out_bits_keep !== 1'b1) begin
        errors++; $display("FAIL full_byte%0d: got v=%b d=%h k=%b want v=1 d=%h k=1", i, bus.out_valid, bus.out_bits_data, bus.out_bits_keep, d[8*i +: 8]); end
      checks++; if (bus.out_bits_last !== (i == 3)) begin errors++; $display("FAIL full_last%0d: got %b want %b", i, bus.out_bits_last, (i == 3)); end
      checks++; if (bus.pkt_len !== 16'(i)) begin errors++; $display("FAIL full_len%0d: got %0d want %0d", i, bus.pkt_len, i); end
    end
    @(negedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.pkt_len !== 16'd0) begin
      errors++; $display("FAIL full_end: got v=%b len=%0d want v=0 len=0", bus.out_valid, bus.pkt_len); end
  endtask

  task automatic test_sparse_back_to_back();
    @(negedge clk); set_in(1'b1, 4'b1010, 32'hDDCCBBAA, 1'b0); bus.out_ready = 1'b1; #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL sparse_in_ready0: got %b want 1", bus.in_ready); end
    @(negedge clk); set_in(1'b1, 4'b0001, 32'h000000EE, 1'b1); #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_bits_data !== 8'hBB || bus.out_bits_last !== 1'b0) begin
      errors++; $display("FAIL sparse_bb: got v=%b d=%h l=%b want v=1 d=bb l=0", bus.out_valid, bus.out_bits_data, bus.out_bits_last); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL sparse_in_ready1: got %b want 0", bus.in_ready); end
    @(negedge clk); #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_bits_data !== 8'hDD || bus.out_bits_last !== 1'b0) begin
      errors++; $display("FAIL sparse_dd: got v=%b d=%h l=%b want v=1 d=dd l=0", bus.out_valid, bus.out_bits_data, bus.out_bits_last); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL sparse_in_ready2: got %b want 1", bus.in_ready); end
    @(negedge clk); set_in(1'b0, '0, '0, 1'b0); #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_bits_data !== 8'hEE || bus.out_bits_last !== 1'b1) begin
      errors++; $display("FAIL sparse_ee: got v=%b d=%h l=%b want v=1 d=ee l=1", bus.out_valid, bus.out_bits_data, bus.out_bits_last); end
    checks++; if (bus.pkt_len !== 16'd2) begin errors++; $display("FAIL sparse_len: got %0d want 2", bus.pkt_len); end
    @(negedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.pkt_len !== 16'd0) begin
      errors++; $display("FAIL sparse_end: got v=%b len=%0d want v=0 len=0", bus.out_valid, bus.pkt_len); end
  endtask

  task automatic test_zero_strobe();
    @(negedge clk); set_in(1'b1, 4'h0, 32'h12345678, 1'b0); bus.out_ready = 1'b1; #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL zero_in_ready0: got %b want 1", bus.in_ready); end
    @(negedge clk); set_in(1'b0, '0, '0, 1'b0); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL zero_drop: got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready); end
    @(negedge clk); set_in(1'b1, 4'h0, 32'hA5A5A5A5, 1'b1); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL zero_in_ready1: got %b want 1", bus.in_ready); end
    @(negedge clk); set_in(1'b0, '0, '0, 1'b0); #1;
    checks++; if ({bus.out_valid, bus.out_bits_data, bus.out_bits_keep, bus.out_bits_last} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin
      errors++; $display("FAIL zero_term: got v=%b d=%h k=%b l=%b want v=1 d=00 k=0 l=1", bus.out_valid, bus.out_bits_data, bus.out_bits_keep, bus.out_bits_last); end
    checks++; if (bus.pkt_len !== 16'd0) begin errors++; $display("FAIL zero_len: got %0d want 0", bus.pkt_len); end
    @(negedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL zero_end: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d;
    d = DW'($urandom);
    @(negedge clk); set_in(1'b1, 4'hF, d, 1'b1); bus.out_ready = 1'b1; #1;
    @(negedge clk); set_in(1'b0, '0, '0, 1'b0); #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_bits_data !== d[7:0]) begin
      errors++; $display("FAIL bp_lane0: got v=%b d=%h want v=1 d=%h", bus.out_valid, bus.out_bits_data, d[7:0]); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); bus.out_ready = 1'b0; #1;
      checks++; if ({bus.out_valid, bus.out_bits_data, bus.out_bits_keep, bus.out_bits_last} !== {1'b1, d[15:8], 1'b1, 1'b0}) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b d=%h k=%b l=%b want v=1 d=%h k=1 l=0", i, bus.out_valid, bus.out_bits_data, bus.out_bits_keep, bus.out_bits_last, d[15:8]); end
      checks++; if (bus.in_ready !== 1'b0 || bus.pkt_len !== 16'd1) begin
        errors++; $display("FAIL bp_stall%0d: got rdy=%b len=%0d want rdy=0 len=1", i, bus.in_ready, bus.pkt_len); end
    end
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); bus.out_ready = 1'b1; #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_bits_data !== d[8*k +: 8] || bus.out_bits_last !== (k == 3)) begin
        errors++; $display("FAIL bp_lane%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", k, bus.out_valid, bus.out_bits_data, bus.out_bits_last, d[8*k +: 8], (k == 3)); end
      checks++; if (bus.pkt_len !== 16'(k)) begin errors++; $display("FAIL bp_len%0d: got %0d want %0d", k, bus.pkt_len, k); end
    end
    @(negedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.pkt_len !== 16'd0) begin
      errors++; $display("FAIL bp_end: got v=%b len=%0d want v=0 len=0", bus.out_valid, bus.pkt_len); end
  endtask

  task automatic test_reset_mid_beat();
    logic [DW-1:0] d;
    logic [DW-1:0] d2;
    d  = DW'($urandom);
    d2 = DW'($urandom);
    @(negedge clk); set_in(1'b1, 4'hF, d, 1'b1); bus.out_ready = 1'b1; #1;
    @(negedge clk); set_in(1'b0, '0, '0, 1'b0); #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_bits_data !== d[23:16] || bus.pkt_len !== 16'd2) begin
      errors++; $display("FAIL rst_pre: got v=%b d=%h len=%0d want v=1 d=%h len=2", bus.out_valid, bus.out_bits_data, bus.pkt_len, d[23:16]); end
    rst_n = 1'b0; #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.pkt_len !== 16'd0 || bus.in_ready !== 1'b1 || bus.out_bits_data !== 8'h00) begin
      errors++; $display("FAIL rst_now: got v=%b len=%0d rdy=%b d=%h want v=0 len=0 rdy=1 d=00", bus.out_valid, bus.pkt_len, bus.in_ready, bus.out_bits_data); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); set_in(1'b1, 4'b0011, d2, 1'b1); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_clean: got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); set_in(1'b0, '0, '0, 1'b0); #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_bits_data !== d2[8*k +: 8] || bus.out_bits_last !== (k == 1) || bus.pkt_len !== 16'(k)) begin
        errors++; $display("FAIL rst_next%0d: got v=%b d=%h l=%b len=%0d want v=1 d=%h l=%b len=%0d", k, bus.out_valid, bus.out_bits_data, bus.out_bits_last, bus.pkt_len, d2[8*k +: 8], (k == 1), k); end
    end
    @(negedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.pkt_len !== 16'd0) begin
      errors++; $display("FAIL rst_end: got v=%b len=%0d want v=0 len=0", bus.out_valid, bus.pkt_len); end
  endtask

  task automatic test_random();
    localparam int N = 150;
    logic [SW-1:0] bs [N];
    logic [DW-1:0] bd [N];
    logic          bl [N];
    exp_t          expq [$];
    exp_t          e;
    int            bi;
    int            hi;
    int            cyc;
    logic          acc;
    logic          prev_stall;
    logic [9:0]    prev_out;
    logic [LW-1:0] model_len;

    // Expected byte stream: enabled lanes ascending, last on the highest
    // enabled lane of a last beat, a keep=0 terminator for empty last beats.
    for (int b = 0; b < N; b++) begin
      bs[b] = ($urandom_range(0, 7) == 0) ? '0 : SW'($urandom);
      bd[b] = DW'($urandom);
      bl[b] = ($urandom_range(0, 3) == 0);
      hi = -1;
      for (int k = 0; k < SW; k++) if (bs[b][k]) hi = k;
      for (int k = 0; k < SW; k++) begin
        if (bs[b][k]) begin
          e.d = bd[b][8*k +: 8]; e.k = 1'b1; e.l = bl[b] && (k == hi);
          expq.push_back(e);
        end
      end
      if (bs[b] == '0 && bl[b]) begin
        e.d = 8'h00; e.k = 1'b0; e.l = 1'b1;
        expq.push_back(e);
      end
    end

    bi = 0; acc = 1'b0; prev_stall = 1'b0; prev_out = '0; model_len = '0; cyc = 0;
    set_in(1'b0, '0, '0, 1'b0);
    while ((bi < N || expq.size() > 0) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (acc) begin
        bus.in_valid = 1'b0;
        bi++;
      end
      if (!bus.in_valid && bi < N && $urandom_range(0, 3) != 0)
        set_in(1'b1, bs[bi], bd[bi], bl[bi]);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      checks++; if (bus.pkt_len !== model_len) begin
        errors++; $display("FAIL rnd_len c%0d: got %0d want %0d", cyc, bus.pkt_len, model_len); end
      if (prev_stall) begin
        checks++; if ({bus.out_valid, bus.out_bits_data, bus.out_bits_keep} !== prev_out) begin
          errors++; $display("FAIL rnd_hold c%0d: got %h want %h", cyc, {bus.out_valid, bus.out_bits_data, bus.out_bits_keep}, prev_out); end
      end
      if (bus.out_valid) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL rnd_extra c%0d: got d=%h want no output", cyc, bus.out_bits_data);
        end else if ({bus.out_bits_data, bus.out_bits_keep, bus.out_bits_last} !== {expq[0].d, expq[0].k, expq[0].l}) begin
          errors++; $display("FAIL rnd_byte c%0d: got d=%h k=%b l=%b want d=%h k=%b l=%b", cyc,
                             bus.out_bits_data, bus.out_bits_keep, bus.out_bits_last, expq[0].d, expq[0].k, expq[0].l);
        end
        if (bus.out_ready && expq.size() > 0) begin
          e = expq.pop_front();
          if (e.l) model_len = '0;
          else if (e.k && model_len != '1) model_len = model_len + 1'b1;
        end
      end else begin
        checks++; if ({bus.out_bits_data, bus.out_bits_keep, bus.out_bits_last} !== 10'd0) begin
          errors++; $display("FAIL rnd_idle c%0d: got %h want 0", cyc, {bus.out_bits_data, bus.out_bits_keep, bus.out_bits_last}); end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = {bus.out_valid, bus.out_bits_data, bus.out_bits_keep};
      acc        = bus.in_valid && bus.in_ready;
    end
    @(negedge clk);
    set_in(1'b0, '0, '0, 1'b0);
    checks++; if (bi < N || expq.size() > 0) begin
      errors++; $display("FAIL rnd_timeout: got beats=%0d pending=%0d want beats=%0d pending=0", bi, expq.size(), N); end
  endtask

  initial begin
    test_reset();
    test_full_beat();
    test_sparse_back_to_back();
    test_zero_strobe();
    test_backpressure();
    test_reset_mid_beat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
